stack_mem_unit: RTL and testbench

Dual-region stack memory that executes the per-cycle strobes issued by the multicycle control unit: main-stack and return-stack pointer push/pop, two registered read ports and two write ports with encoded address and write-data selects. Sits between the control FSM and the datapath registers (IR, ValA/ValB, Res, PC), and is the sole owner of both stack pointers and stack storage.

---
 rtl/stack_mem_unit.sv | 181 ++++++++++++++++++
 tb/tb_stack_mem_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/stack_mem_unit.sv
// Dual-region stack memory: main stack in the low region, return stack above it,
// two registered read ports and two write ports. Optional macro: STACK_BOUNDS_CHECK_EN.
module stack_mem_unit #(
  parameter int DATA_W   = 16,
  parameter int MS_DEPTH = 16,
  parameter int RS_DEPTH = 16,
  parameter int ADDR_W   = $clog2(MS_DEPTH + RS_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MSPWrite,
  input  logic                      MSPop,
  input  logic                      RSPWrite,
  input  logic                      RSPop,
  input  logic                      MemRead1,
  input  logic                      MemRead2,
  input  logic                      MemWrite1,
  input  logic                      MemWrite2,
  input  logic [1:0]                MemDst1,
  input  logic [1:0]                MemDst2,
  input  logic [1:0]                MemData,
  input  logic [DATA_W-1:0]         wdata1,
  input  logic [DATA_W-1:0]         pc_in,
  input  logic [DATA_W-1:0]         res_in,
  input  logic [DATA_W-1:0]         imm_in,
  input  logic [DATA_W-1:0]         valb_in,
  input  logic [ADDR_W-1:0]         imm_addr,
  output logic [DATA_W-1:0]         rd_data1,
  output logic [DATA_W-1:0]         rd_data2,
  output logic [$clog2(MS_DEPTH):0] msp,
  output logic [$clog2(RS_DEPTH):0] rsp,
  output logic                      ms_empty,
  output logic                      ms_full,
  output logic                      rs_empty,
  output logic                      rs_full,
  output logic                      ms_ovf,
  output logic                      ms_unf,
  output logic                      rs_ovf,
  output logic                      rs_unf
);

  localparam int MS_AW     = $clog2(MS_DEPTH);
  localparam int RS_AW     = $clog2(RS_DEPTH);
  localparam int MEM_DEPTH = MS_DEPTH + RS_DEPTH;

  localparam logic [MS_AW:0]    MS_ONE  = 1;
  localparam logic [RS_AW:0]    RS_ONE  = 1;
  localparam logic [MS_AW:0]    MS_FULL = (MS_AW+1)'(MS_DEPTH);
  localparam logic [RS_AW:0]    RS_FULL = (RS_AW+1)'(RS_DEPTH);
  localparam logic [ADDR_W-1:0] RS_BASE = ADDR_W'(MS_DEPTH);

  logic [DATA_W-1:0] r_mem [0:MEM_DEPTH-1];
  logic [MS_AW:0]    r_msp;
  logic [RS_AW:0]    r_rsp;
  logic [MS_AW:0]    w_msp_next;
  logic [RS_AW:0]    w_rsp_next;
  logic              r_ms_ovf, r_ms_unf, r_rs_ovf, r_rs_unf;
  logic              w_ms_ovf_set, w_ms_unf_set, w_rs_ovf_set, w_rs_unf_set;
  logic [ADDR_W-1:0] w_ms_top, w_rs_top;
  logic [ADDR_W-1:0] w_addr1, w_addr2;
  logic              w_ok1, w_ok2;
  logic [DATA_W-1:0] w_wdata2;

  // Pointer next-state; a pop at zero or push at full is the only place the builds differ.
  always_comb begin
    w_msp_next   = r_msp;
    w_rsp_next   = r_rsp;
    w_ms_ovf_set = 1'b0;
    w_ms_unf_set = 1'b0;
    w_rs_ovf_set = 1'b0;
    w_rs_unf_set = 1'b0;
`ifdef STACK_BOUNDS_CHECK_EN
    if (MSPWrite) begin
      if (!MSPop) begin
        if (r_msp == MS_FULL) w_ms_ovf_set = 1'b1;
        else                  w_msp_next   = r_msp + MS_ONE;
      end else begin
        if (r_msp == '0) w_ms_unf_set = 1'b1;
        else             w_msp_next   = r_msp - MS_ONE;
      end
    end
    if (RSPWrite) begin
      if (!RSPop) begin
        if (r_rsp == RS_FULL) w_rs_ovf_set = 1'b1;
        else                  w_rsp_next   = r_rsp + RS_ONE;
      end else begin
        if (r_rsp == '0) w_rs_unf_set = 1'b1;
        else             w_rsp_next   = r_rsp - RS_ONE;
      end
    end
`else
    if (MSPWrite) begin
      if (!MSPop) w_msp_next = {1'b0, r_msp[MS_AW-1:0] + MS_ONE[MS_AW-1:0]};
      else        w_msp_next = {1'b0, r_msp[MS_AW-1:0] - MS_ONE[MS_AW-1:0]};
    end
    if (RSPWrite) begin
      if (!RSPop) w_rsp_next = {1'b0, r_rsp[RS_AW-1:0] + RS_ONE[RS_AW-1:0]};
      else        w_rsp_next = {1'b0, r_rsp[RS_AW-1:0] - RS_ONE[RS_AW-1:0]};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msp    <= '0;
      r_rsp    <= '0;
      r_ms_ovf <= 1'b0;
      r_ms_unf <= 1'b0;
      r_rs_ovf <= 1'b0;
      r_rs_unf <= 1'b0;
    end else begin
      r_msp    <= w_msp_next;
      r_rsp    <= w_rsp_next;
      r_ms_ovf <= r_ms_ovf | w_ms_ovf_set;
      r_ms_unf <= r_ms_unf | w_ms_unf_set;
      r_rs_ovf <= r_rs_ovf | w_rs_ovf_set;
      r_rs_unf <= r_rs_unf | w_rs_unf_set;
    end
  end

  // Tops come from the pre-update pointers, so push-then-write lands on the new top.
  assign w_ms_top = (r_msp == '0) ? '0 : ADDR_W'(r_msp - MS_ONE);
  assign w_rs_top = (r_rsp == '0) ? RS_BASE : RS_BASE + ADDR_W'(r_rsp - RS_ONE);

  always_comb begin
    w_addr1 = '0;
    w_ok1   = 1'b1;
    case (MemDst1)
      2'b00:   w_addr1 = w_ms_top;
      2'b01:   w_addr1 = w_rs_top;
      2'b10:   w_addr1 = imm_addr;
      default: w_ok1   = 1'b0;
    endcase
    if (32'(w_addr1) >= MEM_DEPTH) w_ok1 = 1'b0;
    w_addr2 = '0;
    w_ok2   = 1'b1;
    case (MemDst2)
      2'b00:   w_addr2 = w_ms_top;
      2'b01:   w_addr2 = w_rs_top;
      2'b10:   w_addr2 = imm_addr;
      default: w_ok2   = 1'b0;
    endcase
    if (32'(w_addr2) >= MEM_DEPTH) w_ok2 = 1'b0;
    case (MemData)
      2'b00:   w_wdata2 = pc_in;
      2'b01:   w_wdata2 = res_in;
      2'b10:   w_wdata2 = imm_in;
      default: w_wdata2 = valb_in;
    endcase
  end

  // Port 2 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (MemWrite1 && w_ok1) r_mem[w_addr1] <= wdata1;
      if (MemWrite2 && w_ok2) r_mem[w_addr2] <= w_wdata2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      if (MemRead1) rd_data1 <= w_ok1 ? r_mem[w_addr1] : '0;
      if (MemRead2) rd_data2 <= w_ok2 ? r_mem[w_addr2] : '0;
    end
  end

  assign msp      = r_msp;
  assign rsp      = r_rsp;
  assign ms_empty = (r_msp == '0);
  assign rs_empty = (r_rsp == '0);
  assign ms_full  = (r_msp == MS_FULL);
  assign rs_full  = (r_rsp == RS_FULL);
  assign ms_ovf   = r_ms_ovf;
  assign ms_unf   = r_ms_unf;
  assign rs_ovf   = r_rs_ovf;
  assign rs_unf   = r_rs_unf;

endmodule

// File: tb/tb_stack_mem_unit.sv
// Directed bench for stack_mem_unit; expectations follow STACK_BOUNDS_CHECK_EN if defined.
module tb_stack_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MSPWrite, MSPop, RSPWrite, RSPop;
  logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
  logic [1:0]  MemDst1, MemDst2, MemData;
  logic [15:0] wdata1, pc_in, res_in, imm_in, valb_in;
  logic [4:0]  imm_addr;
  logic [15:0] rd_data1, rd_data2;
  logic [4:0]  msp, rsp;
  logic        ms_empty, ms_full, rs_empty, rs_full;
  logic        ms_ovf, ms_unf, rs_ovf, rs_unf;

  int total = 0;
  int bad   = 0;

  stack_mem_unit dut (
    .clk(clk), .rst(rst),
    .MSPWrite(MSPWrite), .MSPop(MSPop), .RSPWrite(RSPWrite), .RSPop(RSPop),
    .MemRead1(MemRead1), .MemRead2(MemRead2),
    .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
    .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
    .wdata1(wdata1), .pc_in(pc_in), .res_in(res_in), .imm_in(imm_in),
    .valb_in(valb_in), .imm_addr(imm_addr),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .msp(msp), .rsp(rsp),
    .ms_empty(ms_empty), .ms_full(ms_full), .rs_empty(rs_empty), .rs_full(rs_full),
    .ms_ovf(ms_ovf), .ms_unf(ms_unf), .rs_ovf(rs_ovf), .rs_unf(rs_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    MSPWrite = 0; MSPop = 0; RSPWrite = 0; RSPop = 0;
    MemRead1 = 0; MemRead2 = 0; MemWrite1 = 0; MemWrite2 = 0;
    MemDst1 = 2'b00; MemDst2 = 2'b00; MemData = 2'b00;
  endtask

  // Advance past one rising edge, then return strobes to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wdata1 = 0; pc_in = 0; res_in = 0; imm_in = 0; valb_in = 0; imm_addr = 0;
    #2;
    check("rst_msp", msp, 0);
    check("rst_rsp", rsp, 0);
    check("rst_rd1", rd_data1, 0);
    check("rst_ms_empty", ms_empty, 1);
    check("rst_ms_full", ms_full, 0);
    check("rst_flags", {ms_ovf, ms_unf, rs_ovf, rs_unf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Push, write new top from imm_in, read it back.
    MSPWrite = 1; MSPop = 0;
    tick();
    check("push_msp", msp, 1);
    check("push_ms_empty", ms_empty, 0);
    MemWrite2 = 1; MemDst2 = 2'b00; MemData = 2'b10; imm_in = 16'h1234;
    tick();
    MemRead1 = 1; MemDst1 = 2'b00;
    tick();
    check("top_read", rd_data1, 16'h1234);
    check("top_msp", msp, 1);

    // Jump-push: return push with simultaneous main pop.
    RSPWrite = 1; RSPop = 0; MSPWrite = 1; MSPop = 1;
    tick();
    check("jmp_rsp", rsp, 1);
    check("jmp_msp", msp, 0);
    check("jmp_rs_empty", rs_empty, 0);
    MemWrite2 = 1; MemDst2 = 2'b01; MemData = 2'b00; pc_in = 16'h0040;
    tick();
    MemRead2 = 1; MemDst2 = 2'b01;
    tick();
    check("ret_read", rd_data2, 16'h0040);
    check("rd1_hold", rd_data1, 16'h1234);

    // Write conflict at address 5 with read of the old value in the same cycle.
    MemWrite1 = 1; MemDst1 = 2'b10; imm_addr = 5'd5; wdata1 = 16'h1111;
    tick();
    MemWrite1 = 1; MemWrite2 = 1; MemDst1 = 2'b10; MemDst2 = 2'b10; MemData = 2'b10;
    wdata1 = 16'hAAAA; imm_in = 16'h5555; MemRead1 = 1;
    tick();
    check("rdw_old", rd_data1, 16'h1111);
    MemRead2 = 1; MemDst2 = 2'b10;
    tick();
    check("conflict_p2", rd_data2, 16'h5555);

    // Reserved select: reads zero, write dropped.
    MemWrite1 = 1; MemDst1 = 2'b11; wdata1 = 16'hBEEF; MemRead1 = 1;
    tick();
    check("sel11_read", rd_data1, 0);
    MemRead1 = 1; MemDst1 = 2'b10; imm_addr = 5'd0;
    tick();
    check("addr0_kept", rd_data1, 16'h1234);

    // Asynchronous reset mid-run with a write pending.
    MSPWrite = 1; MSPop = 0;
    tick();
    check("pre_rst_msp", msp, 1);
    MemWrite1 = 1; MemDst1 = 2'b10; imm_addr = 5'd5; wdata1 = 16'h9999;
    #1 rst = 1'b1;
    #1;
    check("arst_msp", msp, 0);
    check("arst_rsp", rsp, 0);
    check("arst_rd2", rd_data2, 0);
    check("arst_ms_empty", ms_empty, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    MemRead1 = 1; MemDst1 = 2'b10; imm_addr = 5'd5;
    tick();
    check("rst_blocks_wr", rd_data1, 16'h5555);

    // Bounds: 17 main pushes, then return pop at empty.
    for (int i = 0; i < 17; i++) begin
      MSPWrite = 1; MSPop = 0;
      tick();
    end
`ifdef STACK_BOUNDS_CHECK_EN
    check("bnd_msp", msp, 16);
    check("bnd_ms_full", ms_full, 1);
    check("bnd_ms_ovf", ms_ovf, 1);
`else
    check("wrap_msp", msp, 1);
    check("wrap_ms_full", ms_full, 0);
    check("wrap_ms_ovf", ms_ovf, 0);
`endif
    RSPWrite = 1; RSPop = 1;
    tick();
`ifdef STACK_BOUNDS_CHECK_EN
    check("bnd_rsp", rsp, 0);
    check("bnd_rs_unf", rs_unf, 1);
`else
    check("wrap_rsp", rsp, 15);
    check("wrap_rs_unf", rs_unf, 0);
`endif
    MSPWrite = 1; MSPop = 1;
    tick();
`ifdef STACK_BOUNDS_CHECK_EN
    check("pop_msp", msp, 15);
    check("ovf_sticky", ms_ovf, 1);
`else
    check("pop_msp", msp, 0);
    check("pop_ms_empty", ms_empty, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
